// File: rtl/hit_writer.sv
// hit_writer: captures one NDWORDS-word record and streams it to an Avalon-MM slave as 16-bit writes
module hit_writer #(
   parameter int NDWORDS = 3
) (
   input  logic                   i_clk,
   input  logic                   i_rstn,
   input  logic [31:0]            baseaddr,
   input  logic [31:0]            index,
   input  logic                   write,
   input  logic [32*NDWORDS-1:0]  data,
   output logic                   iready,
   output logic                   o_done,
   output logic                   avm_m0_write,
   output logic [31:0]            avm_m0_address,
   output logic [15:0]            avm_m0_writedata,
   output logic [1:0]             avm_m0_byteenable,
   input  logic                   avm_m0_waitrequest
);
   localparam int NH = 2 * NDWORDS;
   localparam int CW = $clog2(NH);
   localparam logic [CW-1:0] LAST = CW'(NH - 1);
   localparam logic [31:0] STRIDE = 32'(NDWORDS * 4);
   typedef enum logic {IDLE, BUSY} state_t;
   state_t                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [31:0]           base_q, base_d;
   logic [32*NDWORDS-1:0] data_q, data_d;
   logic                  accept, xfer, last;
   assign accept = (state_q == IDLE) && write;
   assign xfer   = (state_q == BUSY) && !avm_m0_waitrequest;
   assign last   = cnt_q == LAST;
   // record state; reset abandons any record in flight
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) state_q <= IDLE;
      else         state_q <= state_d;
   end
   // leave IDLE on a request, return once the final halfword is taken by the slave
   always_comb begin
      state_d = (state_q == IDLE) ? (write ? BUSY : IDLE) : ((xfer && last) ? IDLE : BUSY);
   end
   // handshake outputs decoded from the state and the current transfer
   always_comb begin
      iready       = state_q == IDLE;
      avm_m0_write = state_q == BUSY;
      o_done       = xfer && last;
   end
   // capture the record base address and payload on accept, step the halfword counter per transfer
   always_comb begin
      base_d = accept ? baseaddr + index * STRIDE : base_q;
      data_d = accept ? data : data_q;
      cnt_d  = accept ? '0 : (xfer ? (last ? '0 : cnt_q + 1'b1) : cnt_q);
   end
   // captured record and halfword counter
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         base_q <= '0;
         data_q <= '0;
         cnt_q  <= '0;
      end else begin
         base_q <= base_d;
         data_q <= data_d;
         cnt_q  <= cnt_d;
      end
   end
   assign avm_m0_address    = base_q + {{(31-CW){1'b0}}, cnt_q, 1'b0};
   assign avm_m0_writedata  = data_q[{cnt_q, 4'b0000} +: 16];
   assign avm_m0_byteenable = 2'b11;
endmodule

// File: tb/tb_hit_writer.sv
// tb_hit_writer: randomized and directed checks of hit_writer against a record-level reference model
module tb_hit_writer;
   localparam int NDW = 3;
   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [31:0]    baseaddr = '0, index = '0;
   logic           write = 1'b0;
   logic [95:0]    data = '0;
   logic           waitreq = 1'b0;
   logic           iready, o_done, avm_write;
   logic [31:0]    avm_addr;
   logic [15:0]    avm_wd;
   logic [1:0]     avm_be;
   int             vectors = 0, miscompares = 0;
   logic [31:0]    obs_addr[$], exp_addr[$], obs_waddr[$];
   logic [15:0]    obs_data[$], exp_data[$];
   bit             obs_wr[$], wq[$], inj[$];
   int             obs_done, obs_busy, hold_bad, timeouts;
   bit             acc_ok;
   logic           rst_wr, rst_done;
   logic [31:0]    rst_addr;
   logic [15:0]    rst_data;
   logic [95:0]    rec_d;

   hit_writer #(.NDWORDS(NDW)) dut (
      .i_clk(clk), .i_rstn(rst_n), .baseaddr(baseaddr), .index(index), .write(write), .data(data),
      .iready(iready), .o_done(o_done), .avm_m0_write(avm_write), .avm_m0_address(avm_addr),
      .avm_m0_writedata(avm_wd), .avm_m0_byteenable(avm_be), .avm_m0_waitrequest(waitreq)
   );

   always #5 clk = ~clk;

   // expected halfword stream of one record, straight from the addressing rule
   function automatic void model(input logic [31:0] b, input logic [31:0] ix, input logic [95:0] d);
      logic [31:0] word;
      for (int h = 0; h < 2 * NDW; h++) begin
         word = d[32 * (h / 2) +: 32];
         exp_addr.push_back(b + ix * 32'(NDW * 4) + 32'(2 * h));
         exp_data.push_back((h % 2) ? word[31:16] : word[15:0]);
      end
   endfunction

   task automatic clear_obs();
      obs_addr.delete(); obs_data.delete(); obs_wr.delete(); obs_waddr.delete();
      exp_addr.delete(); exp_data.delete(); wq.delete(); inj.delete();
      obs_done = 0; obs_busy = 0; hold_bad = 0; timeouts = 0;
   endtask

   // drives one request and records what the bus does until iready returns (or reset at cycle rst_at)
   task automatic run_rec(input logic [31:0] b, input logic [31:0] ix, input logic [95:0] d,
                          input bit chain, input int rst_at);
      logic [31:0] pa;
      logic [15:0] pd;
      bit pstall;
      int cyc;
      if (!chain) @(negedge clk);
      write = 1'b1; baseaddr = b; index = ix; data = d; waitreq = 1'b0;
      #1 acc_ok = iready;
      pstall = 1'b0; pa = '0; pd = '0; cyc = 0;
      forever begin
         @(negedge clk);
         write = (inj.size() > 0) ? inj.pop_front() : 1'b0;
         baseaddr = $urandom; index = $urandom; data = {$urandom, $urandom, $urandom};
         waitreq = (wq.size() > 0) ? wq.pop_front() : 1'b0;
         if (cyc == rst_at) rst_n = 1'b0;
         #1;
         if (cyc == rst_at) begin
            rst_wr = avm_write; rst_done = o_done; rst_addr = avm_addr; rst_data = avm_wd;
            write = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            break;
         end
         if (pstall && (avm_addr !== pa || avm_wd !== pd)) hold_bad++;
         pstall = avm_write && waitreq; pa = avm_addr; pd = avm_wd;
         obs_wr.push_back(avm_write);
         if (avm_write) obs_waddr.push_back(avm_addr);
         if (!iready) obs_busy++;
         if (avm_write && !waitreq) begin
            obs_addr.push_back(avm_addr);
            obs_data.push_back(avm_wd);
         end
         if (o_done) obs_done++;
         if (iready) break;
         if (++cyc > 200) begin timeouts++; break; end
      end
      write = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      #1;
      vectors++; if (iready !== 1'b1) begin miscompares++; $display("FAIL reset_iready got %b want 1", iready); end
      vectors++; if (avm_write !== 1'b0) begin miscompares++; $display("FAIL reset_write got %b want 0", avm_write); end
      vectors++; if (o_done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", o_done); end
      vectors++; if (avm_addr !== 32'h0) begin miscompares++; $display("FAIL reset_addr got %h want 0", avm_addr); end
      vectors++; if (avm_wd !== 16'h0) begin miscompares++; $display("FAIL reset_data got %h want 0", avm_wd); end
      vectors++; if (avm_be !== 2'b11) begin miscompares++; $display("FAIL reset_be got %b want 11", avm_be); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      logic [31:0] sa[6] = '{32'h1018, 32'h101A, 32'h101C, 32'h101E, 32'h1020, 32'h1022};
      logic [15:0] sd[6] = '{16'h2222, 16'h1111, 16'h4444, 16'h3333, 16'h6666, 16'h5555};
      clear_obs();
      run_rec(32'h1000, 32'd2, rec_d, 1'b0, -1);
      vectors++; if (acc_ok !== 1'b1) begin miscompares++; $display("FAIL basic_accept got %b want 1", acc_ok); end
      vectors++; if (obs_addr.size() !== 6) begin miscompares++; $display("FAIL basic_count got %0d want 6", obs_addr.size()); end
      else for (int i = 0; i < 6; i++) begin
         vectors++; if (obs_addr[i] !== sa[i] || obs_data[i] !== sd[i]) begin
            miscompares++; $display("FAIL basic_hw%0d got %h/%h want %h/%h", i, obs_addr[i], obs_data[i], sa[i], sd[i]); end
      end
      vectors++; if (obs_done !== 1) begin miscompares++; $display("FAIL basic_done got %0d want 1", obs_done); end
      vectors++; if (obs_busy !== 6) begin miscompares++; $display("FAIL basic_busy got %0d want 6", obs_busy); end
      vectors++; if (timeouts !== 0) begin miscompares++; $display("FAIL basic_timeout got %0d want 0", timeouts); end
   endtask

   task automatic test_wait();
      int held;
      clear_obs();
      model(32'h1000, 32'd2, rec_d);
      wq = '{1'b0, 1'b1, 1'b1, 1'b1};
      run_rec(32'h1000, 32'd2, rec_d, 1'b0, -1);
      held = 0;
      foreach (obs_waddr[i]) if (obs_waddr[i] == 32'h101A) held++;
      vectors++; if (held !== 4) begin miscompares++; $display("FAIL wait_held got %0d want 4", held); end
      vectors++; if (hold_bad !== 0) begin miscompares++; $display("FAIL wait_stable got %0d changes want 0", hold_bad); end
      vectors++; if (obs_busy !== 9) begin miscompares++; $display("FAIL wait_busy got %0d want 9", obs_busy); end
      vectors++; if (obs_done !== 1) begin miscompares++; $display("FAIL wait_done got %0d want 1", obs_done); end
      vectors++; if (obs_addr !== exp_addr || obs_data !== exp_data) begin
         miscompares++; $display("FAIL wait_stream got %p want %p", obs_addr, exp_addr); end
   endtask

   task automatic test_ignore();
      clear_obs();
      model(32'h1000, 32'd2, rec_d);
      inj = '{1'b0, 1'b0, 1'b0, 1'b1};
      run_rec(32'h1000, 32'd2, rec_d, 1'b0, -1);
      vectors++; if (obs_addr !== exp_addr || obs_data !== exp_data) begin
         miscompares++; $display("FAIL ignore_stream got %p / %p want %p / %p", obs_addr, obs_data, exp_addr, exp_data); end
      vectors++; if (obs_busy !== 6) begin miscompares++; $display("FAIL ignore_busy got %0d want 6", obs_busy); end
      vectors++; if (obs_done !== 1) begin miscompares++; $display("FAIL ignore_done got %0d want 1", obs_done); end
   endtask

   task automatic test_reset_mid();
      logic [95:0] d2;
      clear_obs();
      run_rec(32'h1000, 32'd2, rec_d, 1'b0, 2);
      vectors++; if (rst_wr !== 1'b0) begin miscompares++; $display("FAIL rstmid_write got %b want 0", rst_wr); end
      vectors++; if (rst_done !== 1'b0 || obs_done !== 0) begin
         miscompares++; $display("FAIL rstmid_done got %b/%0d want 0/0", rst_done, obs_done); end
      vectors++; if (rst_addr !== 32'h0 || rst_data !== 16'h0) begin
         miscompares++; $display("FAIL rstmid_clear got %h/%h want 0/0", rst_addr, rst_data); end
      vectors++; if (obs_addr.size() !== 2) begin miscompares++; $display("FAIL rstmid_partial got %0d want 2", obs_addr.size()); end
      clear_obs();
      d2 = {$urandom, $urandom, $urandom};
      model(32'h1000, 32'd0, d2);
      run_rec(32'h1000, 32'd0, d2, 1'b1, -1);
      vectors++; if (obs_addr !== exp_addr || obs_data !== exp_data) begin
         miscompares++; $display("FAIL rstmid_next got %p want %p", obs_addr, exp_addr); end
      vectors++; if (obs_busy !== 6 || obs_done !== 1) begin
         miscompares++; $display("FAIL rstmid_next_busy got %0d/%0d want 6/1", obs_busy, obs_done); end
   endtask

   task automatic test_wrap();
      logic [31:0] sa[6] = '{32'hFFFFFFF8, 32'hFFFFFFFA, 32'hFFFFFFFC, 32'hFFFFFFFE, 32'h0, 32'h2};
      clear_obs();
      run_rec(32'hFFFFFFF8, 32'd0, rec_d, 1'b0, -1);
      vectors++; if (obs_addr.size() !== 6) begin miscompares++; $display("FAIL wrap_count got %0d want 6", obs_addr.size()); end
      else for (int i = 0; i < 6; i++) begin
         vectors++; if (obs_addr[i] !== sa[i]) begin
            miscompares++; $display("FAIL wrap_addr%0d got %h want %h", i, obs_addr[i], sa[i]); end
      end
   endtask

   task automatic test_back_to_back();
      logic [95:0] d1, d2;
      logic [31:0] i1, i2;
      bit pat[13];
      clear_obs();
      d1 = {$urandom, $urandom, $urandom}; d2 = {$urandom, $urandom, $urandom};
      i1 = $urandom_range(0, 1000); i2 = $urandom_range(0, 1000);
      model(32'h2000, i1, d1);
      model(32'h8000, i2, d2);
      run_rec(32'h2000, i1, d1, 1'b0, -1);
      run_rec(32'h8000, i2, d2, 1'b1, -1);
      vectors++; if (acc_ok !== 1'b1) begin miscompares++; $display("FAIL b2b_accept got %b want 1", acc_ok); end
      vectors++; if (obs_addr !== exp_addr || obs_data !== exp_data) begin
         miscompares++; $display("FAIL b2b_stream got %p want %p", obs_addr, exp_addr); end
      vectors++; if (obs_done !== 2) begin miscompares++; $display("FAIL b2b_done got %0d want 2", obs_done); end
      for (int i = 0; i < 13; i++) pat[i] = (i != 6);
      vectors++; if (obs_wr.size() < 13) begin miscompares++; $display("FAIL b2b_len got %0d want >=13", obs_wr.size()); end
      else for (int i = 0; i < 13; i++) begin
         vectors++; if (obs_wr[i] !== pat[i]) begin
            miscompares++; $display("FAIL b2b_gap cycle %0d got %b want %b", i, obs_wr[i], pat[i]); end
      end
   endtask

   task automatic test_random();
      logic [95:0] d;
      logic [31:0] b, ix;
      int stalls, s;
      for (int r = 0; r < 20; r++) begin
         clear_obs();
         b = $urandom; ix = $urandom; d = {$urandom, $urandom, $urandom};
         model(b, ix, d);
         stalls = 0;
         for (int h = 0; h < 2 * NDW; h++) begin
            s = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
            stalls += s;
            repeat (s) wq.push_back(1'b1);
            wq.push_back(1'b0);
         end
         for (int k = 0; k < 2 * NDW; k++) inj.push_back(1'($urandom_range(0, 1)));
         run_rec(b, ix, d, 1'b0, -1);
         vectors++; if (obs_addr !== exp_addr || obs_data !== exp_data) begin
            miscompares++; $display("FAIL rand%0d_stream got %p / %p want %p / %p", r, obs_addr, obs_data, exp_addr, exp_data); end
         vectors++; if (obs_busy !== 2 * NDW + stalls || obs_done !== 1) begin
            miscompares++; $display("FAIL rand%0d_busy got %0d/%0d want %0d/1", r, obs_busy, obs_done, 2 * NDW + stalls); end
         vectors++; if (hold_bad !== 0) begin miscompares++; $display("FAIL rand%0d_stable got %0d want 0", r, hold_bad); end
      end
   endtask

   initial begin
      rec_d = {32'h55556666, 32'h33334444, 32'h11112222};
      test_reset();
      test_basic();
      test_wait();
      test_ignore();
      test_reset_mid();
      test_wrap();
      test_back_to_back();
      test_random();
      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/hit_writer.md
HIT_WRITER -- requirements
Module: hit_writer

Interface
REQ-001 The block SHALL have parameter NDWORDS, default 3, giving the number of 32-bit words per record (legal range 1..16).
REQ-002 i_clk  input  1  single clock; all state changes on its rising edge.
REQ-003 i_rstn  input  1  reset, asynchronous assert, active-low.
REQ-004 baseaddr  input  32  byte address of record 0; sampled on request accept.
REQ-005 index  input  32  record index; sampled on request accept.
REQ-006 write  input  1  request strobe; accepted only when iready=1.
REQ-007 data  input  32*NDWORDS  record payload; word k = data[32k+31:32k]; sampled on accept.
REQ-008 iready  output  1  high when a request can be accepted.
REQ-009 o_done  output  1  one-cycle pulse when the last halfword of a record is accepted by the bus.
REQ-010 avm_m0_write  output  1  Avalon-MM write request.
REQ-011 avm_m0_address  output  32  byte address of current halfword.
REQ-012 avm_m0_writedata  output  16  current halfword.
REQ-013 avm_m0_byteenable  output  2  constant 2'b11 while out of reset.
REQ-014 avm_m0_waitrequest  input  1  slave stall; transfer completes on a cycle where write=1 and waitrequest=0.

Function
REQ-015 States SHALL be IDLE and BUSY; IDLE: iready=1, avm_m0_write=0; BUSY: iready=0, avm_m0_write=1.
REQ-016 IDLE->BUSY SHALL occur on the edge where write=1; baseaddr, index, data captured at that edge.
REQ-017 avm_m0_write SHALL first assert in the cycle after accept (latency 1).
REQ-018 Each record SHALL be sent as 2*NDWORDS halfwords, order h=0..2*NDWORDS-1, h even = low half of word h/2, h odd = high half.
REQ-019 Halfword h address SHALL be baseaddr + index*NDWORDS*4 + 2*h, computed modulo 2^32 (wrap silently).
REQ-020 address and writedata SHALL be held stable while waitrequest=1; advance only on a completed transfer.
REQ-021 No transfer SHALL be issued while in IDLE; writes are back-to-back (no idle cycles) when waitrequest=0.
REQ-022 On completion of halfword 2*NDWORDS-1: o_done=1 that cycle, state returns to IDLE at the edge, iready=1 next cycle.
REQ-023 write asserted while BUSY SHALL be ignored (no queuing, no corruption of the captured record).
REQ-024 write asserted in the cycle iready returns high SHALL be accepted normally; minimum record-to-record spacing is 2*NDWORDS+1 cycles.
REQ-025 Halfword counter width SHALL be sized for 2*NDWORDS-1; no counter wrap within a record.
REQ-026 Change of baseaddr/index/data during BUSY SHALL not affect the record in flight.

Reset
REQ-027 On i_rstn=0, asynchronously: state=IDLE, iready=1, o_done=0, avm_m0_write=0, avm_m0_address=0, avm_m0_writedata=0, counter=0, captured record cleared; byteenable=2'b11.
REQ-028 Reset asserted mid-record SHALL abandon the record immediately (write drops in the same cycle); no o_done for it; no resumption after release.
REQ-029 First request after reset release SHALL be accepted on the first rising edge with i_rstn=1 and write=1.

Verification
REQ-030 NDWORDS=3, baseaddr=0x1000, index=2, data words {0x11112222,0x33334444,0x55556666}, waitrequest=0 -> 6 writes at 0x1018,0x101A,0x101C,0x101E,0x1020,0x1022 with data 0x2222,0x1111,0x4444,0x3333,0x6666,0x5555; o_done on 6th; iready low exactly 6 cycles.
REQ-031 Same record, waitrequest=1 for 3 cycles on halfword 1 -> address 0x101A/data 0x1111 held 4 cycles; totals 9 BUSY cycles; one o_done.
REQ-032 write pulsed at halfword 3 with different data/index -> ignored; output sequence identical to REQ-030.
REQ-033 i_rstn low during halfword 2 -> avm_m0_write=0 immediately, no o_done; after release new record index=0 -> writes start at 0x1000.
REQ-034 baseaddr=0xFFFFFFF8, index=0, NDWORDS=3 -> addresses 0xFFFFFFF8,0xFFFFFFFA,0xFFFFFFFC,0xFFFFFFFE,0x00000000,0x00000002.
REQ-035 Two requests back-to-back (second on first cycle iready=1) -> 12 writes, exactly one idle cycle between records, two o_done pulses.
